// File: rtl/common_fifo_sync_pkg.sv
// common_fifo_sync_pkg
//   Shared sizing helpers for the synchronous FIFO family. Any block that
//   mirrors a FIFO occupancy counter should size it with fifo_psize() so the
//   widths always agree with the FIFO itself.
package common_fifo_sync_pkg;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int FIFO_DSIZE_DEF = 8;

  // Number of bits needed to address 'value' distinct items (ceil(log2)).
  function automatic int fifo_clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  // Width of an occupancy count that must hold 0..depth inclusive.
  function automatic int fifo_psize(input int depth);
    return fifo_clog2(depth + 1);
  endfunction

endpackage

// File: rtl/common_fifo_sync_if.sv
// common_fifo_sync_if
//   Handshake bundle of the synchronous FIFO.
//   master : producer/consumer side (drives wdata, wr_en, rd_en)
//   slave  : FIFO side (drives rdata, count, empty, full)
import common_fifo_sync_pkg::*;

interface common_fifo_sync_if #(
  parameter int DSIZE = FIFO_DSIZE_DEF,
  parameter int PSIZE = fifo_psize(FIFO_DEPTH_DEF)
);
  logic [DSIZE-1:0] wdata;
  logic             wr_en;
  logic [DSIZE-1:0] rdata;
  logic             rd_en;
  logic [PSIZE-1:0] count;
  logic             empty;
  logic             full;

  modport master (output wdata, wr_en, rd_en, input rdata, count, empty, full);
  modport slave  (input wdata, wr_en, rd_en, output rdata, count, empty, full);
endinterface

// File: rtl/common_fifo_sync_ram.sv
// common_fifo_ram
//   DEPTH x DSIZE storage with one synchronous write port and one synchronous
//   read port. No reset: contents and the read register power up unknown.
//   Ports: clock, wr_en/waddr/wdata (write), rd_en/raddr/rdata (read, 1-cycle
//   latency, holds when rd_en is low).
module common_fifo_ram #(
  parameter int DEPTH = 4,
  parameter int DSIZE = 8,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rd_en,
  input  logic [AW-1:0]    raddr,
  output logic [DSIZE-1:0] rdata
);
  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[waddr] <= wdata;
    if (rd_en) rdata      <= mem[raddr];
  end
endmodule

// File: rtl/common_fifo_sync.sv
// common_fifo_sync
//   Single-clock FIFO with registered read data, occupancy count and
//   registered empty/full flags. Overflow writes and underflow reads are
//   dropped without side effects.
//   Ports: clock, rst (async, active-high), bus (slave modport: wdata, wr_en,
//   rd_en in; rdata, count, empty, full out).
import common_fifo_sync_pkg::*;

module common_fifo_sync #(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int DSIZE = FIFO_DSIZE_DEF
) (
  input  logic              clock,
  input  logic              rst,
  common_fifo_sync_if.slave bus
);
  localparam int PSIZE = fifo_psize(DEPTH);
  localparam int AW    = fifo_clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PSIZE-1:0] count_q, count_nxt;
  logic             empty_q, full_q;
  logic             rd_seen_q;
  logic             wr_acc, rd_acc;
  logic [DSIZE-1:0] ram_rdata;

  // Pointers can only coincide when empty (read blocked) or full (write
  // blocked), so the RAM never sees a read and write to one address.
  assign wr_acc = bus.wr_en && !full_q;
  assign rd_acc = bus.rd_en && !empty_q;

  always_comb begin
    count_nxt = count_q;
    if (wr_acc && !rd_acc)      count_nxt = count_q + PSIZE'(1);
    else if (rd_acc && !wr_acc) count_nxt = count_q - PSIZE'(1);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      if (rd_acc) rd_seen_q <= 1'b1;
      count_q <= count_nxt;
      // Flags come from the next count so they line up with count exactly.
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == PSIZE'(DEPTH));
    end
  end

  common_fifo_ram #(
    .DEPTH (DEPTH),
    .DSIZE (DSIZE),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .wr_en (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (bus.wdata),
    .rd_en (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset; until the first accepted read after
  // reset the output is forced to zero, which gives the reset value of rdata
  // immediately on an asynchronous reset.
  assign bus.rdata = rd_seen_q ? ram_rdata : '0;
  assign bus.count = count_q;
  assign bus.empty = empty_q;
  assign bus.full  = full_q;
endmodule

// File: tb/tb_common_fifo_sync.sv
`timescale 1ns/1ps
module tb_common_fifo_sync;
  import common_fifo_sync_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #3.367 clock = ~clock;   // ~148.5 MHz

  common_fifo_sync_if #(.DSIZE(8), .PSIZE(fifo_psize(4))) bus4 ();
  common_fifo_sync_if #(.DSIZE(8), .PSIZE(fifo_psize(3))) bus3 ();

  common_fifo_sync #(.DEPTH(4), .DSIZE(8)) dut4 (.clock(clock), .rst(rst), .bus(bus4));
  common_fifo_sync #(.DEPTH(3), .DSIZE(8)) dut3 (.clock(clock), .rst(rst), .bus(bus3));

  // Reference model: a queue of stored words plus the last word read out.
  logic [7:0] q4[$];
  logic [7:0] q3[$];
  logic [7:0] rd4, rd3;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all();
    check("cnt4",   32'(bus4.count), 32'(q4.size()));
    check("empty4", 32'(bus4.empty), 32'(q4.size() == 0));
    check("full4",  32'(bus4.full),  32'(q4.size() == 4));
    check("rdata4", 32'(bus4.rdata), 32'(rd4));
    check("cnt3",   32'(bus3.count), 32'(q3.size()));
    check("empty3", 32'(bus3.empty), 32'(q3.size() == 0));
    check("full3",  32'(bus3.full),  32'(q3.size() == 3));
    check("rdata3", 32'(bus3.rdata), 32'(rd3));
  endtask

  // One clock with the currently driven requests; model follows FIFO rules.
  task automatic tick();
    bit wa4, ra4, wa3, ra3;
    logic [7:0] wd4, wd3;
    wa4 = bus4.wr_en && (q4.size() < 4);
    ra4 = bus4.rd_en && (q4.size() > 0);
    wa3 = bus3.wr_en && (q3.size() < 3);
    ra3 = bus3.rd_en && (q3.size() > 0);
    wd4 = bus4.wdata;
    wd3 = bus3.wdata;
    @(posedge clock);
    if (ra4) rd4 = q4.pop_front();
    if (wa4) q4.push_back(wd4);
    if (ra3) rd3 = q3.pop_front();
    if (wa3) q3.push_back(wd3);
    #1;
    check_all();
  endtask

  task automatic drive4(input bit w, input bit r, input logic [7:0] d);
    bus4.wr_en = w; bus4.rd_en = r; bus4.wdata = d;
  endtask

  task automatic drive3(input bit w, input bit r, input logic [7:0] d);
    bus3.wr_en = w; bus3.rd_en = r; bus3.wdata = d;
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset(input string tag);
    @(posedge clock);
    #2 rst = 1'b1;
    #1;
    check({tag, "_cnt4"},   32'(bus4.count), 0);
    check({tag, "_empty4"}, 32'(bus4.empty), 1);
    check({tag, "_full4"},  32'(bus4.full),  0);
    check({tag, "_rdata4"}, 32'(bus4.rdata), 0);
    check({tag, "_cnt3"},   32'(bus3.count), 0);
    check({tag, "_rdata3"}, 32'(bus3.rdata), 0);
    q4.delete(); q3.delete(); rd4 = '0; rd3 = '0;
    drive4(0, 0, 8'h00); drive3(0, 0, 8'h00);
    repeat (5) @(posedge clock);
    #1 rst = 1'b0;
    check_all();
  endtask

  initial begin
    drive4(0, 0, 8'h00); drive3(0, 0, 8'h00);
    rd4 = '0; rd3 = '0;
    async_reset("rst0");

    // Fill: data counts up only on accepted writes.
    for (int i = 0; i < 6; i++) begin
      drive4(1, 0, 8'(q4.size()));
      tick();
    end
    check("fill_cnt",  32'(bus4.count), 4);
    check("fill_full", 32'(bus4.full),  1);

    // Drain past empty; rdata holds the last word.
    for (int i = 0; i < 6; i++) begin
      drive4(0, 1, 8'h00);
      tick();
    end
    check("drain_rdata", 32'(bus4.rdata), 3);
    check("drain_empty", 32'(bus4.empty), 1);

    // Simultaneous request while empty.
    drive4(1, 1, 8'hA5); tick();
    check("esim_cnt",   32'(bus4.count), 1);
    check("esim_rdata", 32'(bus4.rdata), 3);
    drive4(0, 1, 8'h00); tick();
    check("esim_read",  32'(bus4.rdata), 32'hA5);

    // Simultaneous request while full.
    for (int i = 0; i < 4; i++) begin
      drive4(1, 0, 8'(8'h10 + i)); tick();
    end
    drive4(1, 1, 8'hEE); tick();
    check("fsim_cnt",   32'(bus4.count), 3);
    check("fsim_rdata", 32'(bus4.rdata), 32'h10);
    for (int i = 0; i < 4; i++) begin
      drive4(0, 1, 8'h00); tick();
    end
    check("fsim_last", 32'(bus4.rdata), 32'h13);

    // Alternating single write/read, then random traffic.
    for (int i = 0; i < 10; i++) begin
      drive4(i % 2 == 0, i % 2 == 1, 8'($urandom)); tick();
    end
    for (int i = 0; i < 100; i++) begin
      drive4(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      tick();
    end
    drive4(0, 0, 8'h00);

    // DEPTH = 3: fill and drain several times to cross the pointer wrap.
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 4; i++) begin
        drive3(1, 0, 8'($urandom)); tick();
      end
      check("d3_full", 32'(bus3.full),  1);
      check("d3_cnt",  32'(bus3.count), 3);
      for (int i = 0; i < 2; i++) begin
        drive3(0, 1, 8'h00); tick();
      end
    end
    for (int i = 0; i < 80; i++) begin
      drive3(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      drive4(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      tick();
    end

    // Ensure a nonzero word sits on rdata, then reset mid-cycle.
    drive4(0, 0, 8'h00); drive3(0, 0, 8'h00);
    while (q4.size() > 0) begin drive4(0, 1, 8'h00); tick(); end
    drive4(1, 0, 8'h5A); tick();
    drive4(0, 1, 8'h00); tick();
    check("pre_rst_rdata", 32'(bus4.rdata), 32'h5A);
    async_reset("rst1");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/common_fifo_sync.md
# common_fifo_sync

Single-clock synchronous FIFO with registered read data, occupancy count and registered empty/full flags. It is the general-purpose buffering primitive for the pixel and stream datapaths. A parameterised storage array is wrapped by write/read pointer and occupancy logic. Overflow writes and underflow reads are silently ignored.

## Interface
- DEPTH, default 4: number of storage entries; any integer ≥ 2, power of two not required.
- DSIZE, default 8: data width in bits.
- PSIZE, derived as $clog2(DEPTH+1): width of `count`, so that the value DEPTH is representable.
- clock  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- wdata  input  DSIZE  write data.
- wr_en  input  1  write request.
- rdata  output  DSIZE  read data, registered.
- rd_en  input  1  read request.
- count  output  PSIZE  number of stored entries, 0..DEPTH.
- empty  output  1  high when count == 0.
- full  output  1  high when count == DEPTH.

## Operation
- Write accepted: wr_en && !full. The entry at wr_ptr is written with wdata and wr_ptr advances.
- Read accepted: rd_en && !empty. rdata is loaded with the entry at rd_ptr and rd_ptr advances.
- Rejected requests have no effect: pointers, count, memory contents and rdata are unchanged.
- rdata holds its last value whenever no read is accepted.
- Pointers run 0..DEPTH-1 and wrap explicitly to 0 after DEPTH-1. They are not wrapped by bit overflow.
- count update per cycle:
  - write only: +1
  - read only: −1
  - both accepted, or neither: unchanged
- Simultaneous request when full: the read is accepted and the write is rejected, because `full` is still high in that cycle. The next cycle shows count = DEPTH−1.
- Simultaneous request when empty: the write is accepted and the read is rejected. The next cycle shows count = 1, and rdata is unchanged.
- Simultaneous request when partially filled: both are accepted. Data order is preserved (FIFO order).
- empty and full are registered. They are computed from the next-state count, so they are exact in the same cycle as `count`.
- Reset values: rdata = 0, count = 0, empty = 1, full = 0, wr_ptr = rd_ptr = 0. Memory contents are not reset.

## Timing
- Write to visibility:
  - count/empty/full reflect an accepted write one edge after it.
  - The earliest read of that word is requested on the following cycle.
  - rdata is valid one edge after the accepted read (read latency 1).
- full asserts on the edge that accepts the DEPTH-th write. wr_en in that same cycle is accepted (full was low); from the next cycle it is rejected.
- Asserting rst at any time, including mid-transfer, immediately forces the reset values without waiting for a clock. Deassertion is synchronised externally.
- No combinational path exists from inputs to any output.

## Structure
- The shared package holds a `clog2`-style width function and the PSIZE derivation, so other blocks size counters identically.
- One sub-module, `common_fifo_ram`: a DEPTH×DSIZE array with a synchronous write port and a synchronous read port. It carries no reset.
- The top level holds the pointers, count, flags and accept logic.

## Test plan
- **Reset:** hold rst for 5 clocks at 148.5 MHz. Outputs read count = 0, empty = 1, full = 0, rdata = 0, including when rst is asserted mid-cycle.
- **Fill then drain (DEPTH = 4):**
  - Assert wr_en for 6 cycles with wdata 0,1,2,… incrementing only on accepted writes. count steps 1..4, full rises after the 4th write, and the 5th and 6th writes are ignored.
  - Then assert rd_en for 6 cycles. rdata reads 0,1,2,3, then holds 3; empty rises after the 4th read.
- **Empty simultaneous request:** with count = 0, assert wr_en and rd_en with wdata = 0xA5. Next cycle count = 1 and rdata is unchanged. The following read returns 0xA5.
- **Full simultaneous request:** with count = 4, assert wr_en and rd_en. Next cycle count = 3 and the oldest word appears on rdata. The written word is not stored.
- **Wrap-around:** run 10 cycles of alternating single write/read, then random 50% wr_en/rd_en for 100 cycles. A scoreboard matches rdata order exactly, count equals accepted writes minus accepted reads, and count stays within 0..4.
- **Non-power-of-two:** DEPTH = 3. Fill, then drain across the pointer wrap. Data order is correct and full asserts at count = 3.
